// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU in the execute stage.
// result_o = {remainder, quotient}, valid while ready_o is high; start_i is held until consumed.
module div_unit #(
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                signed_div_i,
    input  logic [DATA_W-1:0]   opdata1_i,
    input  logic [DATA_W-1:0]   opdata2_i,
    input  logic                start_i,
    input  logic                annul_i,
    output logic [2*DATA_W-1:0] result_o,
    output logic                ready_o
);

    localparam int               CNT_W     = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

    state_t state, state_nxt;

    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] dividend;
    logic [DATA_W-1:0] divisor;
    logic [DATA_W-1:0] rem;
    logic [DATA_W-1:0] quot;
    logic              sign1;
    logic              sign2;

    logic              accept;
    logic              last_step;
    logic [DATA_W-1:0] abs1;
    logic [DATA_W-1:0] abs2;
    logic [DATA_W:0]   trial;
    logic [DATA_W:0]   diff;
    logic              q_bit;
    logic [DATA_W-1:0] rem_step;
    logic [DATA_W-1:0] quot_step;
    logic [DATA_W-1:0] rem_fix;
    logic [DATA_W-1:0] quot_fix;

    assign accept    = start_i && !annul_i;
    assign last_step = (cnt == LAST_STEP);

    assign abs1 = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
    assign abs2 = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;

    // The trial remainder is one bit wider so divisors with the MSB set still compare correctly.
    assign trial     = {rem, dividend[DATA_W-1]};
    assign diff      = trial - {1'b0, divisor};
    assign q_bit     = ~diff[DATA_W];
    assign rem_step  = q_bit ? diff[DATA_W-1:0] : trial[DATA_W-1:0];
    assign quot_step = {quot[DATA_W-2:0], q_bit};

    // Signs are latched as zero for DIVU, so the fix-up is a no-op there.
    assign quot_fix = (sign1 ^ sign2) ? -quot_step : quot_step;
    assign rem_fix  = sign1 ? -rem_step : rem_step;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FREE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FREE: begin
                if (accept) begin
                    state_nxt = (opdata2_i == '0) ? BYZERO : ON;
                end
            end
            BYZERO: state_nxt = END;
            ON: begin
                if (annul_i) begin
                    state_nxt = FREE;
                end else if (last_step) begin
                    state_nxt = END;
                end
            end
            END: begin
                if (!start_i) begin
                    state_nxt = FREE;
                end
            end
            default: state_nxt = FREE;
        endcase
    end

    // A divide-by-zero enters END with ready_o low; it rises on the following edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            dividend <= '0;
            divisor  <= '0;
            rem      <= '0;
            quot     <= '0;
            sign1    <= 1'b0;
            sign2    <= 1'b0;
            result_o <= '0;
            ready_o  <= 1'b0;
        end else begin
            case (state)
                FREE: begin
                    ready_o  <= 1'b0;
                    result_o <= '0;
                    cnt      <= '0;
                    rem      <= '0;
                    quot     <= '0;
                    if (accept && opdata2_i != '0) begin
                        dividend <= abs1;
                        divisor  <= abs2;
                        sign1    <= signed_div_i & opdata1_i[DATA_W-1];
                        sign2    <= signed_div_i & opdata2_i[DATA_W-1];
                    end
                end
                ON: begin
                    if (!annul_i) begin
                        rem      <= rem_step;
                        quot     <= quot_step;
                        dividend <= {dividend[DATA_W-2:0], 1'b0};
                        cnt      <= cnt + 1'b1;
                        if (last_step) begin
                            result_o <= {rem_fix, quot_fix};
                            ready_o  <= 1'b1;
                        end
                    end
                end
                END: begin
                    if (start_i) begin
                        ready_o <= 1'b1;
                    end else begin
                        ready_o  <= 1'b0;
                        result_o <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed and randomized checks for div_unit: latency, sign handling, corners,
// annul, hold/release, operand isolation, back-to-back and mid-divide reset.
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int vectors;
    int miscompares;

    div_unit #(.DATA_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .signed_div_i(signed_div_i),
        .opdata1_i   (opdata1_i),
        .opdata2_i   (opdata2_i),
        .start_i     (start_i),
        .annul_i     (annul_i),
        .result_o    (result_o),
        .ready_o     (ready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues a request and waits for ready_o; lat = edges after the start edge, -1 on timeout.
    task automatic do_divide(input logic s, input logic [31:0] a, input logic [31:0] b,
                             output logic [63:0] res, output int lat);
        signed_div_i = s;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        tick();
        lat = 0;
        while (!ready_o && lat < 40) begin
            tick();
            lat++;
        end
        if (!ready_o) lat = -1;
        res = result_o;
    endtask

    task automatic release_start();
        start_i = 1'b0;
        tick();
    endtask

    function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic signed [31:0] sq;
        logic signed [31:0] sr;
        if (b == 32'd0) return 64'd0;
        if (!s) return {a % b, a / b};
        sa = a;
        sb = b;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        sq = sa / sb;
        sr = sa % sb;
        return {sr, sq};
    endfunction

    task automatic test_reset();
        rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
        opdata1_i = '0; opdata2_i = '0;
        tick();
        tick();
        vectors++;
        if (ready_o !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_ready: got %b, expected 0", ready_o);
        end
        vectors++;
        if (result_o !== 64'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_result: got %h, expected 0", result_o);
        end
        rst = 1'b0;
    endtask

    task automatic test_unsigned();
        logic [63:0] res;
        int lat;
        do_divide(1'b0, 32'd100, 32'd7, res, lat);
        vectors++;
        if (lat !== 32) begin
            miscompares++;
            $display("[TB] FAIL divu_latency: got %0d, expected 32", lat);
        end
        vectors++;
        if (res !== {32'd2, 32'd14}) begin
            miscompares++;
            $display("[TB] FAIL divu_100_7: got %h, expected %h", res, {32'd2, 32'd14});
        end
        release_start();
        vectors++;
        if ({ready_o, result_o} !== 65'd0) begin
            miscompares++;
            $display("[TB] FAIL divu_release: got %b/%h, expected 0/0", ready_o, result_o);
        end
    endtask

    task automatic test_signed();
        logic        s_tab   [3] = '{1'b1, 1'b1, 1'b0};
        logic [31:0] a_tab   [3] = '{32'hFFFF_FFF9, 32'd7, 32'hFFFF_FFF9};
        logic [31:0] b_tab   [3] = '{32'd2, 32'hFFFF_FFFE, 32'd2};
        logic [63:0] exp_tab [3] = '{{32'hFFFF_FFFF, 32'hFFFF_FFFD},
                                     {32'h0000_0001, 32'hFFFF_FFFD},
                                     {32'h0000_0001, 32'h7FFF_FFFC}};
        logic [63:0] res;
        int lat;
        for (int i = 0; i < 3; i++) begin
            do_divide(s_tab[i], a_tab[i], b_tab[i], res, lat);
            vectors++;
            if (res !== exp_tab[i] || lat !== 32) begin
                miscompares++;
                $display("[TB] FAIL signed_%0d: got %h (lat %0d), expected %h (lat 32)",
                         i, res, lat, exp_tab[i]);
            end
            release_start();
        end
    endtask

    task automatic test_corners();
        logic [63:0] res;
        int lat;
        do_divide(1'b0, 32'd5, 32'd0, res, lat);
        vectors++;
        if (lat !== 2) begin
            miscompares++;
            $display("[TB] FAIL byzero_latency: got %0d, expected 2", lat);
        end
        vectors++;
        if (res !== 64'd0) begin
            miscompares++;
            $display("[TB] FAIL byzero_result: got %h, expected 0", res);
        end
        release_start();
        do_divide(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, res, lat);
        vectors++;
        if (res !== {32'd0, 32'h8000_0000} || lat !== 32) begin
            miscompares++;
            $display("[TB] FAIL overflow: got %h (lat %0d), expected %h (lat 32)",
                     res, lat, {32'd0, 32'h8000_0000});
        end
        release_start();
        do_divide(1'b0, 32'd0, 32'd9, res, lat);
        vectors++;
        if (res !== 64'd0 || lat !== 32) begin
            miscompares++;
            $display("[TB] FAIL zero_dividend: got %h (lat %0d), expected 0 (lat 32)", res, lat);
        end
        release_start();
    endtask

    task automatic test_annul();
        logic [63:0] res;
        int lat;
        logic seen;
        signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
        tick();
        repeat (10) tick();
        annul_i = 1'b1;
        start_i = 1'b0;
        tick();
        annul_i = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            if (ready_o) seen = 1'b1;
            tick();
        end
        vectors++;
        if (seen !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL annul_on: got ready 1, expected ready to stay 0");
        end
        // A request that arrives together with annul must not be accepted.
        start_i = 1'b1; annul_i = 1'b1;
        tick();
        start_i = 1'b0; annul_i = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            if (ready_o) seen = 1'b1;
            tick();
        end
        vectors++;
        if (seen !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL annul_free: got ready 1, expected ready to stay 0");
        end
        do_divide(1'b0, 32'd9, 32'd4, res, lat);
        vectors++;
        if (res !== {32'd1, 32'd2} || lat !== 32) begin
            miscompares++;
            $display("[TB] FAIL annul_restart: got %h (lat %0d), expected %h (lat 32)",
                     res, lat, {32'd1, 32'd2});
        end
        release_start();
    endtask

    task automatic test_hold();
        logic [63:0] res;
        int lat;
        do_divide(1'b0, 32'd1000, 32'd3, res, lat);
        vectors++;
        if (res !== {32'd1, 32'd333} || lat !== 32) begin
            miscompares++;
            $display("[TB] FAIL hold_result: got %h (lat %0d), expected %h (lat 32)",
                     res, lat, {32'd1, 32'd333});
        end
        for (int i = 0; i < 5; i++) begin
            annul_i   = i[0];
            opdata1_i = $urandom;
            opdata2_i = $urandom;
            tick();
            vectors++;
            if ({ready_o, result_o} !== {1'b1, 32'd1, 32'd333}) begin
                miscompares++;
                $display("[TB] FAIL hold_cycle_%0d: got %b/%h, expected 1/%h",
                         i, ready_o, result_o, {32'd1, 32'd333});
            end
        end
        annul_i = 1'b0;
        release_start();
        vectors++;
        if ({ready_o, result_o} !== 65'd0) begin
            miscompares++;
            $display("[TB] FAIL hold_release: got %b/%h, expected 0/0", ready_o, result_o);
        end
    endtask

    task automatic test_operand_toggle();
        int lat;
        signed_div_i = 1'b1; opdata1_i = 32'hFFFF_FF9C; opdata2_i = 32'd7; start_i = 1'b1;
        tick();
        lat = 0;
        while (!ready_o && lat < 40) begin
            signed_div_i = $urandom_range(0, 1);
            opdata1_i    = $urandom;
            opdata2_i    = $urandom;
            tick();
            lat++;
        end
        vectors++;
        if (result_o !== {32'hFFFF_FFFE, 32'hFFFF_FFF2} || lat !== 32) begin
            miscompares++;
            $display("[TB] FAIL operand_toggle: got %h (lat %0d), expected %h (lat 32)",
                     result_o, lat, {32'hFFFF_FFFE, 32'hFFFF_FFF2});
        end
        release_start();
    endtask

    task automatic test_back_to_back();
        logic [63:0] res;
        int lat;
        do_divide(1'b0, 32'd50, 32'd6, res, lat);
        vectors++;
        if (res !== {32'd2, 32'd8} || lat !== 32) begin
            miscompares++;
            $display("[TB] FAIL b2b_first: got %h (lat %0d), expected %h (lat 32)",
                     res, lat, {32'd2, 32'd8});
        end
        release_start();
        do_divide(1'b1, 32'hFFFF_FFCE, 32'd6, res, lat);
        vectors++;
        if (res !== {32'hFFFF_FFFE, 32'hFFFF_FFF8} || lat !== 32) begin
            miscompares++;
            $display("[TB] FAIL b2b_second: got %h (lat %0d), expected %h (lat 32)",
                     res, lat, {32'hFFFF_FFFE, 32'hFFFF_FFF8});
        end
        release_start();
    endtask

    task automatic test_reset_mid();
        logic [63:0] res;
        int lat;
        signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
        tick();
        repeat (20) tick();
        rst = 1'b1;
        start_i = 1'b0;
        tick();
        vectors++;
        if ({ready_o, result_o} !== 65'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_mid: got %b/%h, expected 0/0", ready_o, result_o);
        end
        rst = 1'b0;
        do_divide(1'b0, 32'd77, 32'd10, res, lat);
        vectors++;
        if (res !== {32'd7, 32'd7} || lat !== 32) begin
            miscompares++;
            $display("[TB] FAIL reset_restart: got %h (lat %0d), expected %h (lat 32)",
                     res, lat, {32'd7, 32'd7});
        end
        release_start();
    endtask

    task automatic test_random();
        logic        s;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] res;
        logic [63:0] expv;
        int          lat;
        int          kind;
        for (int i = 0; i < 250; i++) begin
            s    = $urandom_range(0, 1);
            a    = $urandom;
            kind = $urandom_range(0, 9);
            if (kind == 0)      b = 32'd0;
            else if (kind < 5)  b = $urandom_range(1, 255);
            else if (kind == 5) b = 32'hFFFF_FFFF;
            else                b = $urandom;
            expv = model(s, a, b);
            do_divide(s, a, b, res, lat);
            vectors++;
            if (res !== expv || lat !== ((b == 32'd0) ? 2 : 32)) begin
                miscompares++;
                $display("[TB] FAIL random_%0d: s=%b %h/%h got %h (lat %0d), expected %h",
                         i, s, a, b, res, lat, expv);
            end
            release_start();
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_unsigned();
        test_signed();
        test_corners();
        test_annul();
        test_hold();
        test_operand_toggle();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
